// File: rtl/calc_pkg.sv
// Shared encodings for the BCD calculator: opcodes, FSM states, digit limit.
package calc_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_MUL = 2'b10;
    localparam op_t OP_DIV = 2'b11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_TOBIN = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_TOBCD = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Largest legal value of a single BCD digit.
    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble converter: WIDTH binary bits in, NDIG BCD digits out,
// one bit per cycle, MSB first. Raising go with the counter at zero loads din
// and performs the first shift in the same cycle, so a full conversion takes
// exactly WIDTH cycles. done is high during the final shift.
module calc_bin2bcd #(
    parameter int WIDTH = 16,
    parameter int NDIG  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic [WIDTH-1:0]    din,
    output logic [4*NDIG-1:0]   bcd,
    output logic                done
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]  sreg;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  src_bin;
    logic [4*NDIG-1:0] src_bcd;
    logic [4*NDIG-1:0] adj;

    // Pick fresh or in-flight operands, then apply the add-3 correction per digit.
    always_comb begin
        src_bin = (cnt == '0) ? din : sreg;
        src_bcd = (cnt == '0) ? '0 : bcd;
        adj     = src_bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (src_bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = src_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign done = (cnt == CW'(1));

    // Shift one binary bit into the BCD register per cycle while a conversion runs.
    // The bit leaving the top digit is zero for in-range values; it is parked in
    // the vacated LSB of the binary register, which is never shifted out again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
            bcd  <= '0;
        end else if (cnt != '0 || go) begin
            bcd  <= {adj[4*NDIG-2:0], src_bin[WIDTH-1]};
            sreg <= {src_bin[WIDTH-2:0], adj[4*NDIG-1]};
            cnt  <= (cnt == '0) ? CW'(WIDTH - 1) : cnt - CW'(1);
        end
    end

endmodule

// File: rtl/calc_bcd_alu.sv
// Multi-cycle decimal calculator. Captures two BCD operands and an opcode,
// converts them to binary (Horner), runs add/sub in one cycle or mul/div one
// bit per cycle, converts back to BCD (double-dabble) and pulses done.
// Handshake: start is honoured only in IDLE with done low; busy is high from
// the cycle after acceptance until done rises; done is a one-cycle pulse and the
// result outputs are valid from that cycle until the next DONE.
module calc_bcd_alu
    import calc_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [4*DIGITS-1:0]   a_bcd,
    input  logic [4*DIGITS-1:0]   b_bcd,
    output logic                  busy,
    output logic                  done,
    output logic [8*DIGITS-1:0]   res_bcd,
    output logic [4*DIGITS-1:0]   rem_bcd,
    output logic                  neg,
    output logic                  err,
    output logic [2:0]            dbg_state
);
    localparam int BW = 4 * DIGITS;
    localparam int RW = 8 * DIGITS;
    localparam logic [5:0] DIG_LAST = 6'(DIGITS - 1);
    localparam logic [5:0] BIT_LAST = 6'(BW - 1);

    logic [2:0]    state;
    logic [5:0]    cnt;
    op_t           op_q;
    logic [BW-1:0] a_q, b_q;
    logic [BW-1:0] a_bin, b_bin;
    logic [RW-1:0] wres;
    logic [BW-1:0] wrem;
    logic          neg_r, err_r;

    logic          fault;
    logic [5:0]    dig_idx, bit_idx;
    logic [3:0]    a_dig, b_dig;
    logic [BW-1:0] horner_a, horner_b;
    logic [BW-1:0] bit_mask;
    logic          a_bit, b_bit;
    logic [BW:0]   r_shift;
    logic          q_bit;
    logic [BW-1:0] rem_next;
    logic [RW-1:0] mul_term;

    logic          conv_go;
    logic [RW-1:0] rem_din;
    logic [RW-1:0] res_conv;
    logic [BW-1:0] rem_conv;
    logic          res_conv_done, rem_conv_done;

    assign dbg_state = state;

    // Operand validation: any digit above 9, or a zero divisor.
    always_comb begin
        fault = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a_q[4*i +: 4] > BCD_MAX || b_q[4*i +: 4] > BCD_MAX) begin
                fault = 1'b1;
            end
        end
        if (op_q == OP_DIV && b_q == '0) begin
            fault = 1'b1;
        end
    end

    // Horner step: select the current digit (MS first) and form acc*10 + digit.
    always_comb begin
        dig_idx = DIG_LAST - cnt;
        a_dig   = 4'd0;
        b_dig   = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_idx == 6'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        horner_a = (a_bin << 3) + (a_bin << 1) + BW'(a_dig);
        horner_b = (b_bin << 3) + (b_bin << 1) + BW'(b_dig);
    end

    // One bit of shift-add multiply and restoring divide, MSB first.
    always_comb begin
        bit_idx  = BIT_LAST - cnt;
        bit_mask = BW'(1) << bit_idx;
        a_bit    = |(a_bin & bit_mask);
        b_bit    = |(b_bin & bit_mask);
        mul_term = b_bit ? {{BW{1'b0}}, a_bin} : '0;
        r_shift  = {wrem, a_bit};
        q_bit    = (r_shift >= {1'b0, b_bin});
        rem_next = q_bit ? (r_shift[BW-1:0] - b_bin) : r_shift[BW-1:0];
    end

    assign conv_go = (state == S_TOBCD);
    assign rem_din = (op_q == OP_DIV) ? {{BW{1'b0}}, wrem} : '0;

    calc_bin2bcd #(
        .WIDTH (RW),
        .NDIG  (2 * DIGITS)
    ) u_res_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (conv_go),
        .din   (wres),
        .bcd   (res_conv),
        .done  (res_conv_done)
    );

    calc_bin2bcd #(
        .WIDTH (RW),
        .NDIG  (DIGITS)
    ) u_rem_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (conv_go),
        .din   (rem_din),
        .bcd   (rem_conv),
        .done  (rem_conv_done)
    );

    // Main FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            a_bin   <= '0;
            b_bin   <= '0;
            wres    <= '0;
            wrem    <= '0;
            neg_r   <= 1'b0;
            err_r   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            res_bcd <= '0;
            rem_bcd <= '0;
            neg     <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The done cycle itself is not an accept opportunity.
                    if (start && !done) begin
                        op_q  <= op;
                        a_q   <= a_bcd;
                        b_q   <= b_bcd;
                        busy  <= 1'b1;
                        neg   <= 1'b0;
                        err   <= 1'b0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    a_bin <= '0;
                    b_bin <= '0;
                    wres  <= '0;
                    wrem  <= '0;
                    neg_r <= 1'b0;
                    err_r <= fault;
                    state <= fault ? S_DONE : S_TOBIN;
                end
                S_TOBIN: begin
                    a_bin <= horner_a;
                    b_bin <= horner_b;
                    if (cnt == DIG_LAST) begin
                        cnt   <= '0;
                        state <= S_EXEC;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_ADD: begin
                            wres  <= {{BW{1'b0}}, a_bin} + {{BW{1'b0}}, b_bin};
                            state <= S_TOBCD;
                        end
                        OP_SUB: begin
                            if (a_bin >= b_bin) begin
                                wres  <= {{BW{1'b0}}, a_bin - b_bin};
                                neg_r <= 1'b0;
                            end else begin
                                wres  <= {{BW{1'b0}}, b_bin - a_bin};
                                neg_r <= 1'b1;
                            end
                            state <= S_TOBCD;
                        end
                        OP_MUL: begin
                            wres <= (wres << 1) + mul_term;
                        end
                        default: begin
                            wres <= {wres[RW-2:0], q_bit};
                            wrem <= rem_next;
                        end
                    endcase
                    if (op_q == OP_MUL || op_q == OP_DIV) begin
                        if (cnt == BIT_LAST) begin
                            cnt   <= '0;
                            state <= S_TOBCD;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                S_TOBCD: begin
                    if (res_conv_done && rem_conv_done) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    res_bcd <= err_r ? '0 : res_conv;
                    rem_bcd <= err_r ? '0 : rem_conv;
                    neg     <= neg_r;
                    err     <= err_r;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_bcd_alu.sv
// Directed bench for calc_bcd_alu: a 2-digit instance for the main scenarios and
// a 4-digit instance for the wide multiply.
module tb_calc_bcd_alu;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [7:0]  a_bcd, b_bcd;
    logic        busy, done, neg, err;
    logic [15:0] res_bcd;
    logic [7:0]  rem_bcd;
    logic [2:0]  dbg_state;

    logic        start4;
    logic [1:0]  op4;
    logic [15:0] a4, b4;
    logic        busy4, done4, neg4, err4;
    logic [31:0] res4;
    logic [15:0] rem4;
    logic [2:0]  st4;

    int total;
    int bad;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_TOBCD = 3'd4;

    calc_bcd_alu #(.DIGITS(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a_bcd     (a_bcd),
        .b_bcd     (b_bcd),
        .busy      (busy),
        .done      (done),
        .res_bcd   (res_bcd),
        .rem_bcd   (rem_bcd),
        .neg       (neg),
        .err       (err),
        .dbg_state (dbg_state)
    );

    calc_bcd_alu #(.DIGITS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .op        (op4),
        .a_bcd     (a4),
        .b_bcd     (b4),
        .busy      (busy4),
        .done      (done4),
        .res_bcd   (res4),
        .rem_bcd   (rem4),
        .neg       (neg4),
        .err       (err4),
        .dbg_state (st4)
    );

    // Clock and global watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    // Drive one request on the 2-digit DUT and return edges from sample to done (-1 on timeout).
    task automatic do_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, output int lat);
        @(posedge clk); #1;
        start = 1'b1; op = o; a_bcd = a; b_bcd = b;
        @(posedge clk); #1;
        start = 1'b0; a_bcd = 8'hFF; b_bcd = 8'hFF; op = ~o;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a_bcd = 8'h00; b_bcd = 8'h00;
        start4 = 1'b0; op4 = 2'b00; a4 = 16'h0; b4 = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        total++; if ({busy, done, neg, err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, neg, err}); end
        total++; if ({res_bcd, rem_bcd} !== 24'h0) begin bad++; $display("FAIL reset_data got=%h exp=000000", {res_bcd, rem_bcd}); end
        total++; if (dbg_state !== ST_IDLE || st4 !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d/%0d exp=0", dbg_state, st4); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if ({busy, done, dbg_state} !== 5'b0) begin bad++; $display("FAIL reset_idle got=%b exp=00000", {busy, done, dbg_state}); end
    endtask

    task automatic test_add();
        int lat;
        do_op(2'b00, 8'h12, 8'h23, lat);
        total++; if (lat !== 21) begin bad++; $display("FAIL add_latency got=%0d exp=21", lat); end
        total++; if (res_bcd !== 16'h0035) begin bad++; $display("FAIL add_res got=%h exp=0035", res_bcd); end
        total++; if ({neg, err, rem_bcd} !== 10'h0) begin bad++; $display("FAIL add_flags got=%h exp=0", {neg, err, rem_bcd}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_at_done got=%b exp=0", busy); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b exp=0", done); end
        total++; if (res_bcd !== 16'h0035) begin bad++; $display("FAIL add_hold got=%h exp=0035", res_bcd); end
    endtask

    task automatic test_sub();
        int lat;
        do_op(2'b01, 8'h12, 8'h23, lat);
        total++; if (lat !== 21) begin bad++; $display("FAIL sub_latency got=%0d exp=21", lat); end
        total++; if ({res_bcd, neg} !== {16'h0011, 1'b1}) begin bad++; $display("FAIL sub_neg got=%h/%b exp=0011/1", res_bcd, neg); end
        do_op(2'b01, 8'h23, 8'h23, lat);
        total++; if ({res_bcd, neg, err} !== {16'h0000, 2'b00}) begin bad++; $display("FAIL sub_zero got=%h/%b/%b exp=0000/0/0", res_bcd, neg, err); end
        do_op(2'b01, 8'h91, 8'h19, lat);
        total++; if ({res_bcd, neg} !== {16'h0072, 1'b0}) begin bad++; $display("FAIL sub_pos got=%h/%b exp=0072/0", res_bcd, neg); end
    endtask

    task automatic test_mul();
        int lat;
        do_op(2'b10, 8'h99, 8'h99, lat);
        total++; if (lat !== 28) begin bad++; $display("FAIL mul_latency got=%0d exp=28", lat); end
        total++; if (res_bcd !== 16'h9801) begin bad++; $display("FAIL mul_99x99 got=%h exp=9801", res_bcd); end
        do_op(2'b10, 8'h12, 8'h34, lat);
        total++; if ({res_bcd, rem_bcd} !== {16'h0408, 8'h00}) begin bad++; $display("FAIL mul_12x34 got=%h/%h exp=0408/00", res_bcd, rem_bcd); end
    endtask

    task automatic test_div();
        int lat;
        do_op(2'b11, 8'h99, 8'h07, lat);
        total++; if (lat !== 28) begin bad++; $display("FAIL div_latency got=%0d exp=28", lat); end
        total++; if ({res_bcd, rem_bcd} !== {16'h0014, 8'h01}) begin bad++; $display("FAIL div_99_7 got=%h/%h exp=0014/01", res_bcd, rem_bcd); end
        do_op(2'b11, 8'h45, 8'h06, lat);
        total++; if ({res_bcd, rem_bcd, err} !== {16'h0007, 8'h03, 1'b0}) begin bad++; $display("FAIL div_45_6 got=%h/%h/%b exp=0007/03/0", res_bcd, rem_bcd, err); end
    endtask

    task automatic test_fault();
        int lat;
        do_op(2'b11, 8'h37, 8'h00, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL fault_div0_latency got=%0d exp=2", lat); end
        total++; if ({err, neg, res_bcd, rem_bcd} !== {2'b10, 24'h0}) begin bad++; $display("FAIL fault_div0 got=%b/%h/%h exp=1/0000/00", err, res_bcd, rem_bcd); end
        do_op(2'b00, 8'h05, 8'h05, lat);
        total++; if ({err, res_bcd} !== {1'b0, 16'h0010}) begin bad++; $display("FAIL fault_clear got=%b/%h exp=0/0010", err, res_bcd); end
        do_op(2'b10, 8'h1A, 8'h02, lat);
        total++; if ({lat == 2, err, res_bcd} !== {2'b11, 16'h0}) begin bad++; $display("FAIL fault_digit got=lat%0d/%b/%h exp=lat2/1/0000", lat, err, res_bcd); end
        do_op(2'b00, 8'h03, 8'hB0, lat);
        total++; if ({lat == 2, err} !== 2'b11) begin bad++; $display("FAIL fault_digit_b got=lat%0d/%b exp=lat2/1", lat, err); end
    endtask

    task automatic test_busy_ignore();
        int pulses;
        int first_at;
        logic [15:0] got;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; a_bcd = 8'h99; b_bcd = 8'h99;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0; first_at = -1; got = 16'h0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) begin start = 1'b1; op = 2'b00; a_bcd = 8'h11; b_bcd = 8'h11; end
            if (k == 11) start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses++;
                if (first_at < 0) begin first_at = k; got = res_bcd; end
            end
        end
        total++; if (pulses !== 1) begin bad++; $display("FAIL busy_ignore_pulses got=%0d exp=1", pulses); end
        total++; if ({first_at == 28, got} !== {1'b1, 16'h9801}) begin bad++; $display("FAIL busy_ignore_result got=at%0d/%h exp=at28/9801", first_at, got); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(2'b00, 8'h40, 8'h02, lat);
        // done is high now: a start here must be ignored, the next cycle accepts it.
        start = 1'b1; op = 2'b00; a_bcd = 8'h01; b_bcd = 8'h02;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done_cycle_ignored got=busy%b exp=busy0", busy); end
        @(posedge clk); #1;
        start = 1'b0; a_bcd = 8'h77; b_bcd = 8'h77;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=busy%b exp=busy1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        total++; if ({lat == 21, res_bcd} !== {1'b1, 16'h0003}) begin bad++; $display("FAIL b2b_result got=lat%0d/%h exp=lat21/0003", lat, res_bcd); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int lat;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; a_bcd = 8'h12; b_bcd = 8'h34;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (23) @(posedge clk);
        #1;
        total++; if (dbg_state !== ST_TOBCD) begin bad++; $display("FAIL abort_in_tobcd got=%0d exp=%0d", dbg_state, ST_TOBCD); end
        rst_n = 1'b0;
        #1;
        total++; if ({busy, done, neg, err, res_bcd, rem_bcd} !== 28'h0) begin bad++; $display("FAIL abort_async got=%h exp=0", {busy, done, neg, err, res_bcd, rem_bcd}); end
        total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL abort_state got=%0d exp=0", dbg_state); end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
        do_op(2'b00, 8'h45, 8'h45, lat);
        total++; if ({lat == 21, res_bcd} !== {1'b1, 16'h0090}) begin bad++; $display("FAIL abort_recover got=lat%0d/%h exp=lat21/0090", lat, res_bcd); end
    endtask

    task automatic test_digits4();
        int lat;
        @(posedge clk); #1;
        start4 = 1'b1; op4 = 2'b10; a4 = 16'h9999; b4 = 16'h9999;
        @(posedge clk); #1;
        start4 = 1'b0; a4 = 16'h0; b4 = 16'h0;
        lat = 0;
        while (done4 !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 54) begin bad++; $display("FAIL d4_latency got=%0d exp=54", lat); end
        total++; if (res4 !== 32'h99980001) begin bad++; $display("FAIL d4_mul got=%h exp=99980001", res4); end
        total++; if ({rem4, neg4, err4, busy4} !== 19'h0) begin bad++; $display("FAIL d4_flags got=%h exp=0", {rem4, neg4, err4, busy4}); end
    endtask

    // Test sequence and summary
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_div();
        test_fault();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_digits4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
